// File: rtl/fold_sig_accum.sv
// fold_sig_accum -- MISR signature accumulator for the folded aa/bb pair.
//
// Accepts one aa/bb beat per cycle over a valid/ready handshake, compresses
// each stream into a W-bit MISR signature over a programmed frame length, and
// at frame end presents both signatures plus an equality flag for one cycle
// of done. Signatures and match hold until the next accepted start.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, frame_len  frame request and beat count, sampled in IDLE only
//   in_valid/in_ready beat handshake; in_ready is high only while running
//   aa, bb            folded words for stream A / stream B
//   sig_a, sig_b      running / final signatures
//   done              one-cycle pulse, frame complete
//   match             sig_a == sig_b, captured on entry to DONE
//   busy              block is not idle
//   mm_cnt            (FOLD_SIG_MISMATCH_CNT_EN only) saturating count of
//                     accepted beats with aa != bb
//
// Optional feature macro: FOLD_SIG_MISMATCH_CNT_EN
module fold_sig_accum #(
   parameter int             W     = 8,
   parameter int             LEN_W = 8,
   parameter logic [W-1:0]   POLY  = 'h1D
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     aa,
   input  logic [W-1:0]     bb,
   output logic [W-1:0]     sig_a,
   output logic [W-1:0]     sig_b,
   output logic             done,
   output logic             match,
   output logic             busy
`ifdef FOLD_SIG_MISMATCH_CNT_EN
   ,
   output logic [LEN_W-1:0] mm_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [LEN_W-1:0] count;
   logic             beat;
   logic             last_beat;
   logic [W-1:0]     sig_a_nxt, sig_b_nxt;

   // One MISR step: shift left, fold the outgoing MSB back through the taps,
   // then absorb the new data word.
   function automatic logic [W-1:0] misr_step(input logic [W-1:0] sig,
                                              input logic [W-1:0] d);
      misr_step = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : '0) ^ d;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next state plus outputs decoded purely from the state register.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = (frame_len == '0) ? DONE : RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && count == LEN_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign beat      = in_valid & in_ready;
   assign last_beat = beat & (count == LEN_W'(1));
   assign sig_a_nxt = misr_step(sig_a, aa);
   assign sig_b_nxt = misr_step(sig_b, bb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_a <= '0;
         sig_b <= '0;
         count <= '0;
         match <= 1'b0;
      end else if (state == IDLE && start) begin
         sig_a <= '0;
         sig_b <= '0;
         count <= frame_len;
         // A zero-length frame goes straight to DONE with both signatures
         // still zero, so its match flag is already known to be set.
         match <= (frame_len == '0);
      end else if (beat) begin
         sig_a <= sig_a_nxt;
         sig_b <= sig_b_nxt;
         count <= count - LEN_W'(1);
         if (last_beat) match <= (sig_a_nxt == sig_b_nxt);
      end
   end

`ifdef FOLD_SIG_MISMATCH_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         mm_cnt <= '0;
      else if (state == IDLE && start)    mm_cnt <= '0;
      else if (beat && aa != bb && mm_cnt != '1)
                                          mm_cnt <= mm_cnt + LEN_W'(1);
   end
`endif

endmodule

// File: tb/tb_fold_sig_accum.sv
// tb_fold_sig_accum -- self-checking bench for fold_sig_accum.
// Drives inputs at the falling edge and samples outputs there as well, so
// every observation is half a cycle away from the active edge.
module tb_fold_sig_accum;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] frame_len;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] aa, bb;
   logic [7:0] sig_a, sig_b;
   logic       done, match, busy;
`ifdef FOLD_SIG_MISMATCH_CNT_EN
   logic [7:0] mm_cnt;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] va [0:255];
   logic [7:0] vb [0:255];

   typedef struct {
      int         rdy_bad;   // beats where in_ready was not high before driving
      int         done_early;
      logic       done_d, busy_d, rdy_d, m_d;
      logic [7:0] sa_d, sb_d, mm_d;
      logic       done_a, busy_a, m_a;
      logic [7:0] sa_a, sb_a;
   } obs_t;

   fold_sig_accum dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .frame_len (frame_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .aa        (aa),
      .bb        (bb),
      .sig_a     (sig_a),
      .sig_b     (sig_b),
      .done      (done),
      .match     (match),
      .busy      (busy)
`ifdef FOLD_SIG_MISMATCH_CNT_EN
      ,
      .mm_cnt    (mm_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference signature: polynomial-style multiply-by-x modulo x^8+x^4+x^3+x^2+1,
   // then add the data word, written with integer arithmetic.
   function automatic logic [7:0] model_sig(input bit use_b, input int n);
      int s = 0;
      for (int i = 0; i < n; i++) begin
         s = s * 2;
         if (s >= 256) s = (s - 256) ^ 'h1D;
         s = s ^ int'(use_b ? vb[i] : va[i]);
      end
      return s[7:0];
   endfunction

   function automatic logic [7:0] model_mm(input int n);
      int c = 0;
      for (int i = 0; i < n; i++) if (va[i] != vb[i] && c < 255) c++;
      return c[7:0];
   endfunction

   // Runs one frame of len beats from IDLE; gap<0 picks a random 0..2 idle
   // cycles before each beat, gap>=0 is a fixed count. Observes the DONE
   // cycle and the cycle after; the calling test does the comparing.
   task automatic run_frame(input int len, input int gap, input bit mid_start,
                            output obs_t o);
      o.rdy_bad = 0;
      o.done_early = 0;
      @(negedge clk);
      start = 1'b1; frame_len = len[7:0];
      @(negedge clk);
      start = 1'b0; frame_len = 8'($urandom);
      for (int i = 0; i < len; i++) begin
         int g = (gap < 0) ? $urandom_range(2, 0) : gap;
         for (int k = 0; k < g; k++) begin
            in_valid = 1'b0; aa = 8'($urandom); bb = 8'($urandom);
            if (mid_start) begin start = 1'b1; frame_len = 8'd1; end
            @(negedge clk);
            start = 1'b0;
            if (done !== 1'b0 || in_ready !== 1'b1) o.done_early++;
         end
         if (in_ready !== 1'b1) o.rdy_bad++;
         in_valid = 1'b1; aa = va[i]; bb = vb[i];
         @(negedge clk);
         if (i < len - 1 && done !== 1'b0) o.done_early++;
      end
      in_valid = 1'b0; aa = 8'($urandom); bb = 8'($urandom);
      o.done_d = done;  o.busy_d = busy; o.rdy_d = in_ready; o.m_d = match;
      o.sa_d   = sig_a; o.sb_d   = sig_b;
`ifdef FOLD_SIG_MISMATCH_CNT_EN
      o.mm_d = mm_cnt;
`else
      o.mm_d = 8'd0;
`endif
      // A start in the DONE cycle must not launch a frame.
      start = 1'b1; frame_len = 8'd3;
      @(negedge clk);
      start = 1'b0;
      o.done_a = done; o.busy_a = busy; o.m_a = match;
      o.sa_a   = sig_a; o.sb_a = sig_b;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; frame_len = 8'd0; in_valid = 1'b0;
      aa = 8'd0; bb = 8'd0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({sig_a, sig_b, done, match, in_ready, busy} !== 20'd0)
         $display("FAIL reset_outputs got sa=%h sb=%h done=%b match=%b rdy=%b busy=%b want all zero",
                  sig_a, sig_b, done, match, in_ready, busy);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({done, in_ready, busy} !== 3'd0)
         $display("FAIL reset_release got done=%b rdy=%b busy=%b want 0", done, in_ready, busy);
      else n_pass++;
   endtask

   task automatic test_single_beat();
      obs_t o;
      va[0] = 8'h5A; vb[0] = 8'h5A;
      run_frame(1, 0, 1'b0, o);
      n_checks++;
      if (o.rdy_bad != 0 || o.done_d !== 1'b1 || o.busy_d !== 1'b1 || o.rdy_d !== 1'b0)
         $display("FAIL single_handshake got rdy_bad=%0d done=%b busy=%b rdy=%b want 0,1,1,0",
                  o.rdy_bad, o.done_d, o.busy_d, o.rdy_d);
      else n_pass++;
      n_checks++;
      if (o.sa_d !== 8'h5A || o.sb_d !== 8'h5A || o.m_d !== 1'b1)
         $display("FAIL single_result got sa=%h sb=%h match=%b want 5a 5a 1", o.sa_d, o.sb_d, o.m_d);
      else n_pass++;
      n_checks++;
      if (o.busy_a !== 1'b0 || o.done_a !== 1'b0 || o.sa_a !== 8'h5A || o.m_a !== 1'b1)
         $display("FAIL single_after got busy=%b done=%b sa=%h match=%b want 0 0 5a 1",
                  o.busy_a, o.done_a, o.sa_a, o.m_a);
      else n_pass++;
   endtask

   task automatic test_divergent();
      obs_t o;
      va[0] = 8'h01; va[1] = 8'h02; vb[0] = 8'h01; vb[1] = 8'h03;
      run_frame(2, 0, 1'b0, o);
      n_checks++;
      if (o.done_d !== 1'b1 || o.sa_d !== 8'h00 || o.sb_d !== 8'h01 || o.m_d !== 1'b0)
         $display("FAIL divergent got done=%b sa=%h sb=%h match=%b want 1 00 01 0",
                  o.done_d, o.sa_d, o.sb_d, o.m_d);
      else n_pass++;
`ifdef FOLD_SIG_MISMATCH_CNT_EN
      n_checks++;
      if (o.mm_d !== 8'd1) $display("FAIL divergent_mm got %0d want 1", o.mm_d);
      else n_pass++;
`endif
   endtask

   task automatic test_feedback();
      obs_t o;
      va[0] = 8'h80; va[1] = 8'h00; vb[0] = 8'h80; vb[1] = 8'h00;
      run_frame(2, 0, 1'b0, o);
      n_checks++;
      if (o.sa_d !== 8'h1D || o.sb_d !== 8'h1D || o.m_d !== 1'b1)
         $display("FAIL feedback got sa=%h sb=%h match=%b want 1d 1d 1", o.sa_d, o.sb_d, o.m_d);
      else n_pass++;
   endtask

   task automatic test_zero_len();
      obs_t o;
      run_frame(0, 0, 1'b0, o);
      n_checks++;
      if (o.done_d !== 1'b1 || o.rdy_d !== 1'b0 || o.sa_d !== 8'h00 || o.sb_d !== 8'h00 || o.m_d !== 1'b1)
         $display("FAIL zero_len got done=%b rdy=%b sa=%h sb=%h match=%b want 1 0 00 00 1",
                  o.done_d, o.rdy_d, o.sa_d, o.sb_d, o.m_d);
      else n_pass++;
      n_checks++;
      if (o.busy_a !== 1'b0 || o.done_a !== 1'b0)
         $display("FAIL zero_len_after got busy=%b done=%b want 0 0", o.busy_a, o.done_a);
      else n_pass++;
   endtask

   task automatic test_gaps_ignored_start();
      obs_t r, g;
      va[0] = 8'h11; va[1] = 8'h22; va[2] = 8'h93;
      vb[0] = 8'h11; vb[1] = 8'h22; vb[2] = 8'h94;
      run_frame(3, 0, 1'b0, r);
      run_frame(3, 2, 1'b1, g);
      n_checks++;
      if (g.done_early != 0 || g.rdy_bad != 0 || g.done_d !== 1'b1)
         $display("FAIL gaps_count got early=%0d rdy_bad=%0d done=%b want 0 0 1",
                  g.done_early, g.rdy_bad, g.done_d);
      else n_pass++;
      n_checks++;
      if (g.sa_d !== model_sig(0, 3) || g.sb_d !== model_sig(1, 3) || g.sa_d !== r.sa_d
          || g.sb_d !== r.sb_d || g.m_d !== 1'b0)
         $display("FAIL gaps_result got sa=%h sb=%h match=%b want %h %h 0",
                  g.sa_d, g.sb_d, g.m_d, model_sig(0, 3), model_sig(1, 3));
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      obs_t o;
      int bad = 0;
      @(negedge clk);
      start = 1'b1; frame_len = 8'd4;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; aa = 8'hC3; bb = 8'h3C;
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, in_ready, done, sig_a, sig_b} !== 19'd0)
         $display("FAIL reset_mid got busy=%b rdy=%b done=%b sa=%h sb=%h want all zero",
                  busy, in_ready, done, sig_a, sig_b);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL reset_mid_nodone got %0d bad cycles want 0", bad);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
      run_frame(4, 0, 1'b0, o);
      n_checks++;
      if (o.done_d !== 1'b1 || o.sa_d !== model_sig(0, 4) || o.sb_d !== model_sig(1, 4))
         $display("FAIL reset_mid_fresh got done=%b sa=%h sb=%h want 1 %h %h",
                  o.done_d, o.sa_d, o.sb_d, model_sig(0, 4), model_sig(1, 4));
      else n_pass++;
   endtask

   task automatic test_random();
      obs_t o;
      for (int f = 0; f < 25; f++) begin
         int len = $urandom_range(12, 1);
         logic [7:0] ea, eb;
         for (int i = 0; i < len; i++) begin
            va[i] = 8'($urandom);
            vb[i] = ($urandom_range(2, 0) == 0) ? 8'($urandom) : va[i];
         end
         if (f % 5 == 0) for (int i = 0; i < len; i++) vb[i] = va[i];
         ea = model_sig(0, len);
         eb = model_sig(1, len);
         run_frame(len, -1, f[0], o);
         n_checks++;
         if (o.done_early != 0 || o.rdy_bad != 0 || o.done_d !== 1'b1 || o.sa_d !== ea
             || o.sb_d !== eb || o.m_d !== (ea == eb))
            $display("FAIL random_%0d got early=%0d rdy_bad=%0d done=%b sa=%h sb=%h match=%b want 0 0 1 %h %h %b",
                     f, o.done_early, o.rdy_bad, o.done_d, o.sa_d, o.sb_d, o.m_d, ea, eb, ea == eb);
         else n_pass++;
         n_checks++;
         if (o.busy_a !== 1'b0 || o.sa_a !== ea || o.sb_a !== eb || o.m_a !== (ea == eb))
            $display("FAIL random_hold_%0d got busy=%b sa=%h sb=%h match=%b want 0 %h %h %b",
                     f, o.busy_a, o.sa_a, o.sb_a, o.m_a, ea, eb, ea == eb);
         else n_pass++;
`ifdef FOLD_SIG_MISMATCH_CNT_EN
         n_checks++;
         if (o.mm_d !== model_mm(len))
            $display("FAIL random_mm_%0d got %0d want %0d", f, o.mm_d, model_mm(len));
         else n_pass++;
`endif
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_divergent();
      test_feedback();
      test_zero_len();
      test_gaps_ignored_start();
      test_reset_mid_frame();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
